// File: rtl/bit_proc_core.sv
// bit_proc_core
// -------------
// Tiny one-bit processor in the style of the MC14500. Each instruction is one
// 8-bit word read from a combinational program memory:
//   [7:4] opcode, [3] sel (1 = scratch bit, 0 = external input/output bit),
//   [2:0] bit index.
// The result register rr is the single accumulator bit. Every instruction
// takes a FETCH cycle and an EXEC cycle. A jump takes one extra cycle (TGT),
// in which the word after the JMP supplies the target address.
//
// Configuration macro: BIT_PROC_JUMP_EN
//   defined   -> opcode B (JMP) is a conditional jump through the TGT state
//   undefined -> opcode B is a NOP and no TGT logic is built
//
// Parameters:
//   PC_W     program counter / program address width (2..8)
//   RST_VEC  PC value loaded by reset
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   prog_addr  program address (the PC register)
//   prog_data  instruction word from program memory, same-cycle valid
//   in_data    external input bits
//   out_data   registered output bits
//   out_wr     high during the EXEC cycle of a STO/STOC to an output bit
//   rr         current result register
//   halted     high while in the HALT state
module bit_proc_core #(
  parameter int              PC_W    = 4,
  parameter logic [PC_W-1:0] RST_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  input  logic [7:0]      in_data,
  output logic [7:0]      out_data,
  output logic            out_wr,
  output logic            rr,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
`ifdef BIT_PROC_JUMP_EN
    TGT   = 2'd2,
`endif
    HALT  = 2'd3
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic            rr_q;
  logic [7:0]      scratch;
  logic [7:0]      out_q;

  logic [3:0]      opcode;
  logic            sel;
  logic [2:0]      idx;
  logic            src;
  logic            store_bit;
  logic [PC_W-1:0] pc_inc;

  // Decode of the held instruction word. The source bit comes either from
  // the scratch bits or from the external inputs.
  always_comb begin
    opcode    = ir[7:4];
    sel       = ir[3];
    idx       = ir[2:0];
    src       = sel ? scratch[idx] : in_data[idx];
    // STO (8) stores rr, STOC (9) stores its complement
    store_bit = opcode[0] ? ~rr_q : rr_q;
    // natural wrap from 2^PC_W-1 back to 0
    pc_inc    = pc + PC_ONE;
  end

  // Main FSM. Every architectural register is written only here, so an
  // asynchronous reset in any state drops the instruction in flight cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RST_VEC;
      ir      <= 8'h00;
      rr_q    <= 1'b0;
      scratch <= 8'h00;
      out_q   <= 8'h00;
    end else begin
      case (state)
        FETCH: begin
          ir    <= prog_data;
          pc    <= pc_inc;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (opcode)
            4'h1: rr_q <= src;
            4'h2: rr_q <= ~src;
            4'h3: rr_q <= rr_q & src;
            4'h4: rr_q <= rr_q & ~src;
            4'h5: rr_q <= rr_q | src;
            4'h6: rr_q <= rr_q | ~src;
            4'h7: rr_q <= rr_q ^ src;
            4'h8, 4'h9: begin
              if (sel) scratch[idx] <= store_bit;
              else     out_q[idx]   <= store_bit;
            end
            // PC already points past SKZ, so one more step skips a word
            4'hA: if (!rr_q) pc <= pc_inc;
`ifdef BIT_PROC_JUMP_EN
            4'hB: state <= TGT;
`endif
            4'hC: state <= HALT;
            default: ;
          endcase
        end
`ifdef BIT_PROC_JUMP_EN
        // prog_data is the word after the JMP; only its low PC_W bits matter
        TGT: begin
          pc    <= rr_q ? prog_data[PC_W-1:0] : pc_inc;
          state <= FETCH;
        end
`endif
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // out_wr is decoded from registered state so it spans exactly the EXEC
  // cycle whose closing edge updates out_data.
  always_comb begin
    prog_addr = pc;
    out_data  = out_q;
    rr        = rr_q;
    halted    = (state == HALT);
    out_wr    = (state == EXEC) && (opcode[3:1] == 3'b100) && !sel;
  end

endmodule

// File: tb/tb_bit_proc_core.sv
// tb_bit_proc_core
// ----------------
// Directed bench for bit_proc_core with PC_W=4 and RST_VEC=0. The program
// memory is a 16-word array read combinationally through prog_addr.
// Outputs are sampled on the falling clock edge. Jump tests run only when
// BIT_PROC_JUMP_EN is defined; otherwise JMP is checked as a NOP.
module tb_bit_proc_core;

  logic       clk;
  logic       rst;
  logic [3:0] progAddr;
  logic [7:0] progData;
  logic [7:0] inData;
  logic [7:0] outData;
  logic       outWr;
  logic       rr;
  logic       halted;

  logic [7:0] progMem [16];

  int numCompared   = 0;
  int numMismatched = 0;

  bit_proc_core #(.PC_W(4), .RST_VEC(4'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_addr (progAddr),
    .prog_data (progData),
    .in_data   (inData),
    .out_data  (outData),
    .out_wr    (outWr),
    .rr        (rr),
    .halted    (halted)
  );

  assign progData = progMem[progAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance a number of rising edges and park on the next falling edge
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 16; i++) progMem[i] = 8'h00;
  endtask

  // Hold reset for two edges, check the reset state, release on a falling edge
  task automatic applyReset(input string tag);
    rst = 1'b1;
    applyStimulus(2);
    checkOutput({tag, "_rst_addr"},   progAddr, 4'h0);
    checkOutput({tag, "_rst_out"},    outData,  8'h00);
    checkOutput({tag, "_rst_outwr"},  outWr,    1'b0);
    checkOutput({tag, "_rst_rr"},     rr,       1'b0);
    checkOutput({tag, "_rst_halted"}, halted,   1'b0);
    rst = 1'b0;
  endtask

  logic       wrSeen;
  logic [7:0] expRr3;

  initial begin
    rst    = 1'b1;
    inData = 8'h00;
    clearMem();
    $display("[TB] start");

    // LD in[0]; STO out[3]; HLT
    progMem[0] = 8'h10; progMem[1] = 8'h83; progMem[2] = 8'hC0;
    inData = 8'h01;
    applyReset("t1");
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("t1_outwr_cycle%0d", c + 1), outWr, (c == 3));
      if (c == 3) checkOutput("t1_out_before_edge", outData, 8'h00);
    end
    checkOutput("t1_out", outData, 8'h08);
    checkOutput("t1_rr",  rr,      1'b1);
    applyStimulus(2);
    checkOutput("t1_halted", halted, 1'b1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("t1_halt_addr%0d", c), progAddr, 4'h3);
    end
    checkOutput("t1_halted_hold", halted, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t1_async_addr",   progAddr, 4'h0);
    checkOutput("t1_async_halted", halted,   1'b0);
    checkOutput("t1_async_out",    outData,  8'h00);

    // LD in[1]; ANDC scr[2]; XOR in[0]; STOC scr[5]; LD scr[5]; STO out[0]; HLT
    clearMem();
    progMem[0] = 8'h11; progMem[1] = 8'h4A; progMem[2] = 8'h70; progMem[3] = 8'h9D;
    progMem[4] = 8'h1D; progMem[5] = 8'h80; progMem[6] = 8'hC0;
    inData = 8'h03;
    applyReset("t2");
    wrSeen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1);
      if (c <= 10) wrSeen = wrSeen | outWr;
      if (c == 2)  checkOutput("t2_rr_ld",   rr, 1'b1);
      if (c == 4)  checkOutput("t2_rr_andc", rr, 1'b1);
      if (c == 6)  checkOutput("t2_rr_xor",  rr, 1'b0);
      if (c == 10) checkOutput("t2_rr_ldscr", rr, 1'b1);
    end
    checkOutput("t2_no_outwr", wrSeen,  1'b0);
    checkOutput("t2_out",      outData, 8'h01);

    // in=A5: LDC in1; AND in5; AND in3; OR in1; ORC in1; NOP(D); XOR in2; STOC out7; HLT
    clearMem();
    progMem[0] = 8'h21; progMem[1] = 8'h35; progMem[2] = 8'h33; progMem[3] = 8'h51;
    progMem[4] = 8'h61; progMem[5] = 8'hD0; progMem[6] = 8'h72; progMem[7] = 8'h97;
    progMem[8] = 8'hC0;
    inData = 8'hA5;
    expRr3 = 8'b0011_0011;
    applyReset("t3");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(2);
      checkOutput($sformatf("t3_rr_op%0d", k), rr, expRr3[k]);
    end
    checkOutput("t3_out", outData, 8'h80);

    // SKZ with rr=0 at 0x0 region and at 0xF (wrap), then SKZ with rr=1
    clearMem();
    progMem[0] = 8'h10; progMem[1] = 8'h81; progMem[2] = 8'h10; progMem[3] = 8'hA0;
    progMem[4] = 8'h82; progMem[15] = 8'hA0;
    inData = 8'h00;
    applyReset("t4");
    applyStimulus(8);
    checkOutput("t4_skip_addr", progAddr, 4'h5);
    inData = 8'hFF;
    applyStimulus(21);
    checkOutput("t4_wrap_fetch", progAddr, 4'h0);
    applyStimulus(1);
    checkOutput("t4_wrap_skip", progAddr, 4'h1);
    applyStimulus(2);
    checkOutput("t4_skipped_ld", outData, 8'h00);
    applyStimulus(4);
    checkOutput("t4_noskip_addr", progAddr, 4'h4);
    checkOutput("t4_noskip_rr",   rr,       1'b1);
    applyStimulus(2);
    checkOutput("t4_out", outData, 8'h04);

`ifdef BIT_PROC_JUMP_EN
    // NOP; LD in[0]; JMP; target word FE (upper bits ignored)
    clearMem();
    progMem[0] = 8'h00; progMem[1] = 8'h10; progMem[2] = 8'hB0; progMem[3] = 8'hFE;
    progMem[14] = 8'hC0;
    inData = 8'h01;
    applyReset("t5");
    applyStimulus(6);
    checkOutput("t5_tgt_addr", progAddr, 4'h3);
    applyStimulus(1);
    checkOutput("t5_jump_taken", progAddr, 4'hE);
    inData = 8'h00;
    applyReset("t5b");
    applyStimulus(7);
    checkOutput("t5_jump_not_taken", progAddr, 4'h4);
    inData = 8'h01;
    applyReset("t5c");
    applyStimulus(6);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_tgtrst_addr",   progAddr, 4'h0);
    checkOutput("t5_tgtrst_rr",     rr,       1'b0);
    checkOutput("t5_tgtrst_outwr",  outWr,    1'b0);
    checkOutput("t5_tgtrst_halted", halted,   1'b0);
    checkOutput("t5_tgtrst_out",    outData,  8'h00);
    applyStimulus(1);
    checkOutput("t5_tgtrst_hold", progAddr, 4'h0);
`else
    // LD in[0]; JMP (acts as NOP); STO out[2]; HLT
    clearMem();
    progMem[0] = 8'h10; progMem[1] = 8'hB0; progMem[2] = 8'h82; progMem[3] = 8'hC0;
    inData = 8'h01;
    applyReset("t5");
    applyStimulus(4);
    checkOutput("t5_jmp_nop_addr", progAddr, 4'h2);
    applyStimulus(2);
    checkOutput("t5_jmp_nop_out", outData, 8'h04);
    applyStimulus(2);
    checkOutput("t5_halted", halted, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/bit_proc_core.md
BIT_PROC_CORE -- requirements
Module: bit_proc_core

Interface
REQ-001 The block SHALL provide parameter PC_W, default 4, as the program counter and program address width (legal range 2..8).
REQ-002 The block SHALL provide parameter RST_VEC, default 0, as the PC value loaded on reset (PC_W bits).
REQ-003 The block SHALL provide port clk  input  1  as its single clock; all state SHALL update on the rising edge.
REQ-004 The block SHALL provide port rst  input  1  as its reset, which SHALL be asynchronous and active-high.
REQ-005 The block SHALL provide port prog_addr  output  PC_W  carrying the program address, equal to the PC register.
REQ-006 The block SHALL provide port prog_data  input  8  carrying the instruction word from combinational program memory, valid in the same cycle.
REQ-007 The block SHALL provide port in_data  input  8  carrying the external input bits.
REQ-008 The block SHALL provide port out_data  output  8  carrying the registered output bits.
REQ-009 The block SHALL provide port out_wr  output  1  as a one-cycle pulse marking an out_data bit write.
REQ-010 The block SHALL provide port rr  output  1  carrying the current result register.
REQ-011 The block SHALL provide port halted  output  1  asserted in the HALT state.

Function
REQ-012 The FSM SHALL have states FETCH, EXEC, TGT and HALT, and SHALL leave reset in FETCH.
REQ-013 In FETCH: IR<=prog_data; PC<=PC+1 modulo 2^PC_W; next state EXEC.
REQ-014 Decode: opcode=IR[7:4]; sel=IR[3]; idx=IR[2:0]; the source bit SHALL be scratch[idx] when sel=1, else in_data[idx].
REQ-015 In EXEC, opcodes 0..7 SHALL update RR as follows: 0 NOP no change; 1 LD RR<=src; 2 LDC RR<=~src; 3 AND RR<=RR&src; 4 ANDC RR<=RR&~src; 5 OR RR<=RR|src; 6 ORC RR<=RR|~src; 7 XOR RR<=RR^src.
REQ-016 In EXEC, opcode 8 STO / 9 STOC SHALL write RR / ~RR to scratch[idx] when sel=1, else to out_data[idx] with out_wr=1 for exactly that EXEC cycle.
REQ-017 In EXEC, opcode A SKZ SHALL set PC<=PC+1 when RR=0 (skip next word) and leave PC unchanged otherwise.
REQ-018 In EXEC, opcode B JMP SHALL transition to TGT (see Configuration); in TGT, prog_data is the target word: RR=1 -> PC<=prog_data[PC_W-1:0]; RR=0 -> PC<=PC+1; next state FETCH.
REQ-019 In EXEC, opcode C HLT SHALL enter HALT; HALT SHALL hold all state, with halted=1, until rst.
REQ-020 In EXEC, opcodes D..F SHALL behave as NOP.
REQ-021 All non-HLT, non-JMP EXEC cycles SHALL return to FETCH; CPI SHALL be 2, or 3 for JMP.
REQ-022 out_wr SHALL be 0 in every cycle except a STO/STOC EXEC with sel=0.
REQ-023 PC increments in FETCH, SKZ and TGT SHALL wrap from 2^PC_W-1 to 0 without error.
REQ-024 Target bits prog_data[7:PC_W] SHALL be ignored.
REQ-025 Store then load of the same scratch bit in consecutive instructions SHALL read the stored value (no hazard, due to the 2-cycle CPI).

Reset
REQ-026 While rst=1: PC=RST_VEC, IR=0, RR=0, scratch=0, out_data=0, out_wr=0, halted=0, state=FETCH.
REQ-027 Reset asserted in any state (including mid-JMP in TGT, or in HALT) SHALL abort the instruction with no partial write.
REQ-028 The first fetch SHALL occur at the first rising clk edge after rst deasserts.

Configuration
REQ-029 Macro BIT_PROC_JUMP_EN SHALL gate the JMP opcode: when defined, opcode B SHALL behave per REQ-018; when undefined, opcode B SHALL be a NOP, TGT SHALL be unreachable, and its logic SHALL be omitted.

Verification
REQ-030 Reset then program LD in[0], STO out[3] with in_data=0x01 -> out_data=0x08, one out_wr pulse in cycle 4, rr=1.
REQ-031 Program LD in[1], ANDC scr[2], XOR in[0], STOC scr[5] with in=0x03 and scratch=0 -> RR sequence 1,1,0; scratch[5]=1; no out_wr.
REQ-032 With JMP_EN defined and PC_W=4: LD in[0]=1, JMP, word 0x0E -> next prog_addr=0xE; with in[0]=0 -> next prog_addr=0x4.
REQ-033 With RR=0, SKZ at address 0xF -> PC wraps and the instruction at 0x0 is skipped; the next fetch is at 0x1.
REQ-034 HLT -> halted=1 and prog_addr frozen for 10 cycles; rst pulse mid-HALT -> prog_addr=RST_VEC, halted=0.
REQ-035 rst asserted in TGT -> no PC load from the target word; all outputs at their reset values within the same cycle.
